// File: rtl/ni_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single network-interface slave.
// Optional watchdog abort is enabled by defining NI_ARB_WATCHDOG_EN.
module ni_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;

    logic req0, req1;
    logic timeout;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Granted master's request, selected by the latched grant.
    logic        g_cyc, g_stb, g_we;
    logic [31:0] g_adr, g_dat;
    logic [3:0]  g_sel;

    always_comb begin
        g_cyc = grant_q ? m1_cyc_i : m0_cyc_i;
        g_stb = grant_q ? m1_stb_i : m0_stb_i;
        g_we  = grant_q ? m1_we_i  : m0_we_i;
        g_adr = grant_q ? m1_adr_i : m0_adr_i;
        g_dat = grant_q ? m1_dat_i : m0_dat_i;
        g_sel = grant_q ? m1_sel_i : m0_sel_i;
    end

`ifdef NI_ARB_WATCHDOG_EN
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    logic [15:0] wdt_q, wdt_d;

    // Cleared on the grant edge, so it counts stalled BUSY cycles since grant.
    always_comb begin
        wdt_d = wdt_q;
        if (state_q == IDLE && (req0 || req1)) begin
            wdt_d = 16'd0;
        end else if (state_q == BUSY && !s_ack_i) begin
            wdt_d = wdt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdt_q <= 16'd0;
        end else begin
            wdt_q <= wdt_d;
        end
    end

    assign timeout = (state_q == BUSY) && !s_ack_i && (wdt_q == TMO);
`else
    logic unused_cfg;
    assign unused_cfg = ^(32'(TIMEOUT_CYCLES));
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_adr_o      = 32'd0;
        s_dat_o      = 32'd0;
        s_sel_o      = 4'd0;
        m0_ack_o     = 1'b0;
        m0_err_o     = 1'b0;
        m0_dat_o     = 32'd0;
        m1_ack_o     = 1'b0;
        m1_err_o     = 1'b0;
        m1_dat_o     = 32'd0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On contention the master that was not served last wins.
                    grant_d = (req0 && req1) ? ~last_grant_q : req1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_cyc_o = g_cyc;
                s_stb_o = g_stb;
                s_we_o  = g_we;
                s_adr_o = g_adr;
                s_dat_o = g_dat;
                s_sel_o = g_sel;
                if (grant_q) begin
                    m1_ack_o = s_ack_i;
                    m1_dat_o = s_dat_i;
                    m1_err_o = timeout;
                end else begin
                    m0_ack_o = s_ack_i;
                    m0_dat_o = s_dat_i;
                    m0_err_o = timeout;
                end
                if (s_ack_i || timeout) begin
                    last_grant_d = grant_q;
                    state_d      = GAP;
                end else if (!g_cyc) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_ni_wb_arbiter.sv
// Directed bench for ni_wb_arbiter: reset, single read, round-robin, m1 write,
// watchdog (either build), mid-transaction reset and cycle drop.
module tb_ni_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;

    int checks = 0;
    int failures = 0;

    ni_wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 3ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0; m0_sel_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0; m1_sel_i = 0;
        s_ack_i = 0; s_dat_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [165:0] got;
        idle_inputs();
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        tick();
        tick();
        settle();
        got = {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
               m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", got);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0000_0010; m0_sel_i = 4'hF;
        settle();
        checks++;
        if (s_stb_o !== 1'b0) begin failures++; $display("FAIL read_idle_stb got=%0b exp=0", s_stb_o); end
        tick();
        settle();
        checks++;
        if (s_stb_o !== 1'b1 || s_adr_o !== 32'h0000_0010 || s_we_o !== 1'b0) begin
            failures++;
            $display("FAIL read_grant got stb=%0b adr=%h we=%0b exp stb=1 adr=00000010 we=0", s_stb_o, s_adr_o, s_we_o);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            settle();
            checks++;
            if (m0_ack_o !== 1'b0 || s_stb_o !== 1'b1) begin
                failures++;
                $display("FAIL read_wait%0d got ack=%0b stb=%0b exp ack=0 stb=1", i, m0_ack_o, s_stb_o);
            end
        end
        tick();
        s_ack_i = 1; s_dat_i = 32'h1234_5678;
        settle();
        checks++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h1234_5678 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL read_ack got ack=%0b dat=%h m1ack=%0b exp ack=1 dat=12345678 m1ack=0", m0_ack_o, m0_dat_o, m1_ack_o);
        end
        tick();
        s_ack_i = 0; s_dat_i = 0;
        settle();
        checks++;
        if (s_stb_o !== 1'b0 || m0_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL read_gap got stb=%0b ack=%0b exp stb=0 ack=0", s_stb_o, m0_ack_o);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_g;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_00A0;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_00B0;
        for (int t = 0; t < 4; t++) begin
            exp_g = t[0];
            tick();
            s_ack_i = 1; s_dat_i = 32'h100 + t;
            settle();
            checks++;
            if (s_adr_o !== (exp_g ? 32'h0000_00B0 : 32'h0000_00A0) || m0_ack_o !== ~exp_g || m1_ack_o !== exp_g) begin
                failures++;
                $display("FAIL rr_grant%0d got adr=%h ack0=%0b ack1=%0b exp master=%0d", t, s_adr_o, m0_ack_o, m1_ack_o, exp_g);
            end
            tick();
            s_ack_i = 0;
            if (t == 3) idle_inputs();
            settle();
            checks++;
            if (s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) begin
                failures++;
                $display("FAIL rr_gap%0d got stb=%0b cyc=%0b exp 0", t, s_stb_o, s_cyc_o);
            end
            tick();
        end
    endtask

    task automatic test_write_m1();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h4000_0000;
        m1_dat_i = 32'hA5A5_A5A5; m1_sel_i = 4'hF;
        tick();
        settle();
        checks++;
        if (s_we_o !== 1'b1 || s_adr_o !== 32'h4000_0000 || s_dat_o !== 32'hA5A5_A5A5 || s_sel_o !== 4'hF) begin
            failures++;
            $display("FAIL wr_fwd got we=%0b adr=%h dat=%h sel=%h exp we=1 adr=40000000 dat=a5a5a5a5 sel=f", s_we_o, s_adr_o, s_dat_o, s_sel_o);
        end
        s_ack_i = 1;
        settle();
        checks++;
        if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack got ack1=%0b ack0=%0b exp ack1=1 ack0=0", m1_ack_o, m0_ack_o);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_watchdog();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0C00;
        tick();
`ifdef NI_ARB_WATCHDOG_EN
        for (int i = 1; i <= 7; i++) begin
            tick();
            settle();
            checks++;
            if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
                failures++;
                $display("FAIL wdt_early%0d got err=%0b stb=%0b exp err=0 stb=1", i, m0_err_o, s_stb_o);
            end
        end
        tick();
        settle();
        checks++;
        if (m0_err_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin
            failures++;
            $display("FAIL wdt_fire got err0=%0b ack0=%0b err1=%0b exp err0=1 ack0=0 err1=0", m0_err_o, m0_ack_o, m1_err_o);
        end
        tick();
        settle();
        checks++;
        if (m0_err_o !== 1'b0 || s_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL wdt_gap got err=%0b stb=%0b exp 0", m0_err_o, s_stb_o);
        end
        idle_inputs();
        tick();
        settle();
        checks++;
        if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL wdt_idle got cyc=%0b exp=0", s_cyc_o); end
`else
        for (int i = 1; i <= 20; i++) begin
            tick();
            settle();
            checks++;
            if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
                failures++;
                $display("FAIL nowdt_busy%0d got err=%0b stb=%0b exp err=0 stb=1", i, m0_err_o, s_stb_o);
            end
        end
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        tick();
`endif
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [165:0] got;
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_0D00;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle_inputs();
        settle();
        got = {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
               m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o};
        checks++;
        if (got !== '0) begin failures++; $display("FAIL rstmid_outputs got=%0h exp=0", got); end
        s_ack_i = 1; s_dat_i = 32'h5555_AAAA;
        settle();
        checks++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_late_ack got ack0=%0b ack1=%0b exp 0", m0_ack_o, m1_ack_o);
        end
        tick();
        settle();
        checks++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_late_ack2 got ack0=%0b ack1=%0b cyc=%0b exp 0", m0_ack_o, m1_ack_o, s_cyc_o);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_cyc_drop();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0E00;
        m1_adr_i = 32'h0000_0F00;
        tick();
        settle();
        checks++;
        if (s_adr_o !== 32'h0000_0E00) begin failures++; $display("FAIL drop_grant got adr=%h exp=00000e00", s_adr_o); end
        tick();
        m0_cyc_i = 0; m0_stb_i = 0;
        m1_cyc_i = 1; m1_stb_i = 1;
        settle();
        checks++;
        if (s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_busy got cyc=%0b ack0=%0b ack1=%0b exp 0", s_cyc_o, m0_ack_o, m1_ack_o);
        end
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        s_ack_i = 1;
        settle();
        checks++;
        if (s_stb_o !== 1'b0 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_gap got stb=%0b ack0=%0b ack1=%0b exp 0", s_stb_o, m0_ack_o, m1_ack_o);
        end
        tick();
        s_ack_i = 0;
        tick();
        s_ack_i = 1;
        settle();
        checks++;
        if (s_adr_o !== 32'h0000_0E00 || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_priority got adr=%h ack0=%0b ack1=%0b exp adr=00000e00 ack0=1 ack1=0", s_adr_o, m0_ack_o, m1_ack_o);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=expired exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_m1();
        test_watchdog();
        test_reset_mid();
        test_cyc_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ni_wb_arbiter.md
NI_WB_ARBITER -- requirements
Module: ni_wb_arbiter

Interface
REQ-001 The block SHALL expose parameter TIMEOUT_CYCLES, default 1024, giving the watchdog limit in clk cycles; legal range 1..65535.
REQ-002 The block SHALL expose port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL expose port rst_n, input, 1, a synchronous active-low reset sampled on the rising clk edge.
REQ-004 The block SHALL expose, for N in {0,1}, port mN_cyc_i, input, 1, master N Wishbone cycle.
REQ-005 The block SHALL expose port mN_stb_i, input, 1, master N strobe.
REQ-006 The block SHALL expose port mN_we_i, input, 1, master N write enable.
REQ-007 The block SHALL expose port mN_adr_i, input, 32, master N address.
REQ-008 The block SHALL expose port mN_dat_i, input, 32, master N write data.
REQ-009 The block SHALL expose port mN_sel_i, input, 4, master N byte select.
REQ-010 The block SHALL expose port mN_ack_o, output, 1, master N acknowledge.
REQ-011 The block SHALL expose port mN_err_o, output, 1, master N error (watchdog abort).
REQ-012 The block SHALL expose port mN_dat_o, output, 32, master N read data.
REQ-013 The block SHALL expose ports s_cyc_o, s_stb_o, s_we_o (each output, 1), s_adr_o, s_dat_o (each output, 32) and s_sel_o (output, 4), the forwarded request toward the network-interface slave.
REQ-014 The block SHALL expose ports s_ack_i (input, 1) and s_dat_i (input, 32), the network-interface acknowledge and read data.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and GAP.
REQ-016 A master N SHALL request when mN_cyc_i and mN_stb_i are both high.
REQ-017 In IDLE, if any master requests, the FSM SHALL latch grant and move to BUSY on the next edge.
- The winner SHALL be the sole requester.
- If both request, the winner SHALL be the master that is not in last_grant (round-robin).
REQ-018 last_grant SHALL reset to 1, so master 0 wins the first simultaneous contention.
REQ-019 In BUSY, the s_* outputs SHALL combinationally equal the granted master's signals.
- In IDLE and GAP, all s_* outputs SHALL be 0.
REQ-020 In BUSY, mG_ack_o SHALL equal s_ack_i and mG_dat_o SHALL equal s_dat_i for the granted master G; the non-granted master's ack, err and dat SHALL be 0.
REQ-021 A cycle with s_ack_i high in BUSY SHALL move the FSM to GAP and update last_grant to G.
REQ-022 GAP SHALL last exactly one cycle with s_stb_o low, so the slave never sees a stale strobe; the FSM then returns to IDLE.
- Minimum request-to-request turnaround is 3 cycles.
REQ-023 If the granted master drops mG_cyc_i in BUSY without an ack, the FSM SHALL go to GAP without updating last_grant.
REQ-024 A request arriving in GAP SHALL wait until IDLE; the non-granted master SHALL never observe ack or err.
REQ-025 s_ack_i seen in IDLE or GAP SHALL be ignored (no master ack).

Reset
REQ-026 While rst_n is low at a clk edge, the FSM SHALL go to IDLE, grant to 0, last_grant to 1, and the watchdog counter to 0.
- As a consequence, all outputs SHALL read 0 in the following cycle.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction with no ack to either master.

Configuration
REQ-028 Macro NI_ARB_WATCHDOG_EN SHALL control the watchdog.
- Defined: a 16-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_ack_i.
- Defined: when the counter reaches TIMEOUT_CYCLES, mG_err_o SHALL pulse high for one cycle with mG_ack_o low, and the FSM SHALL go to GAP, updating last_grant.
- Defined: s_ack_i and timeout in the same cycle SHALL be treated as ack, with no err.
- Not defined: there SHALL be no counter, mN_err_o SHALL be tied to 0, and BUSY SHALL wait indefinitely.

Verification
REQ-029 Scenario: m0 reads adr 0x0000_0010, slave acks 4 cycles after grant with 0x1234_5678 -> m0_ack_o is a 1-cycle pulse, m0_dat_o=0x1234_5678, and s_stb_o is 0 in the GAP cycle.
REQ-030 Scenario: m0 and m1 request in the same cycle after reset -> m0 is served first, then m1; with both requests held, grants alternate 0,1,0,1.
REQ-031 Scenario: m1 writes 0x4000_0000 with dat 0xA5A5_A5A5 and sel 0xF while m0 is idle -> s_adr_o, s_dat_o and s_sel_o match m1 exactly; m0_ack_o stays 0.
REQ-032 Scenario: with NI_ARB_WATCHDOG_EN defined and TIMEOUT_CYCLES=8, the slave never acks -> m0_err_o pulses 8 cycles after grant, then the FSM returns to IDLE; without the macro, the FSM stays in BUSY.
REQ-033 Scenario: rst_n is pulled low 2 cycles into a BUSY transaction -> all outputs are 0 the next cycle, and a later s_ack_i produces no master ack.
REQ-034 Scenario: m0 drops cyc mid-BUSY -> GAP then IDLE, and a pending m0 request still has priority next, because last_grant was not updated.
